// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: picks a winner per
// transaction, drives one registered memory strobe, then returns ack/err/rdata.
module data_mem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 32,
    parameter int RR_MODE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              last_grant, last_grant_d;
    logic              grant_id, grant_id_d;
    logic              lat_we, lat_we_d;

    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_write_d, mem_read_d;
    logic              p0_ack_d, p0_err_d, p1_ack_d, p1_err_d;
    logic [DATA_W-1:0] p0_rdata_d, p1_rdata_d;
    logic              busy_d;

    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_in_range;
    logic [DATA_W-1:0] access_rdata;

    // Winner selection: contention goes to the port that did not win last time
    // in round-robin mode, otherwise port 0 always takes it.
    always_comb begin
        win = 1'b0;
        if (p0_req && p1_req) begin
            win = (RR_MODE != 0) ? ~last_grant : 1'b0;
        end else if (p1_req) begin
            win = 1'b1;
        end
        win_we       = win ? p1_we    : p0_we;
        win_addr     = win ? p1_addr  : p0_addr;
        win_wdata    = win ? p1_wdata : p0_wdata;
        win_in_range = (win_addr < ADDR_W'(DEPTH));
        access_rdata = lat_we ? '0 : mem_rdata;
    end

    // The mem_addr/mem_wdata flops double as the latched request parameters:
    // they are loaded at grant and only need to survive the single ACCESS cycle.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d      = state;
        last_grant_d = last_grant;
        grant_id_d   = grant_id;
        lat_we_d     = lat_we;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        p0_ack_d     = 1'b0;
        p0_err_d     = 1'b0;
        p0_rdata_d   = '0;
        p1_ack_d     = 1'b0;
        p1_err_d     = 1'b0;
        p1_rdata_d   = '0;

        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    last_grant_d = win;
                    grant_id_d   = win;
                    lat_we_d     = win_we;
                    if (win_in_range) begin
                        state_d     = ACCESS;
                        mem_addr_d  = win_addr;
                        mem_wdata_d = win_wdata;
                        mem_write_d = win_we;
                        mem_read_d  = ~win_we;
                    end else begin
                        state_d = RESP;
                        if (win) begin
                            p1_ack_d = 1'b1;
                            p1_err_d = 1'b1;
                        end else begin
                            p0_ack_d = 1'b1;
                            p0_err_d = 1'b1;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (grant_id) begin
                    p1_ack_d   = 1'b1;
                    p1_rdata_d = access_rdata;
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = access_rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state uses non-blocking assignments so every flop samples the
        // pre-edge values regardless of statement order.
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            grant_id   <= grant_id_d;
            lat_we     <= lat_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_write  <= mem_write_d;
            mem_read   <= mem_read_d;
            p0_ack     <= p0_ack_d;
            p0_err     <= p0_err_d;
            p0_rdata   <= p0_rdata_d;
            p1_ack     <= p1_ack_d;
            p1_err     <= p1_err_d;
            p1_rdata   <= p1_rdata_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus, each backed by its own memory model.
module tb_data_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_init = 1'b1;

    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;

    logic          rr_p0_ack, rr_p0_err, rr_p1_ack, rr_p1_err, rr_mem_write, rr_mem_read, rr_busy;
    logic [DW-1:0] rr_p0_rdata, rr_p1_rdata, rr_mem_wdata, rr_mem_rdata;
    logic [AW-1:0] rr_mem_addr;
    logic          fp_p0_ack, fp_p0_err, fp_p1_ack, fp_p1_err, fp_mem_write, fp_mem_read, fp_busy;
    logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wdata, fp_mem_rdata;
    logic [AW-1:0] fp_mem_addr;

    logic [31:0] mem_rr [32];
    logic [31:0] mem_fp [32];

    exp_t q_rr[$];
    exp_t q_fp[$];

    int vectors = 0;
    int miscompares = 0;
    int write_cycles = 0;
    int read_cycles = 0;
    int acks_rr = 0;
    int p1_acks_rr = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .RR_MODE(1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(rr_p0_ack), .p0_err(rr_p0_err), .p0_rdata(rr_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(rr_p1_ack), .p1_err(rr_p1_err), .p1_rdata(rr_p1_rdata),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_write(rr_mem_write),
        .mem_read(rr_mem_read), .mem_rdata(rr_mem_rdata), .busy(rr_busy)
    );

    data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .RR_MODE(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(fp_p0_ack), .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(fp_p1_ack), .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_write(fp_mem_write),
        .mem_read(fp_mem_read), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    // Memory models: preloaded Data[i] = i*5, synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) begin
                mem_rr[i] <= 32'(i * 5);
                mem_fp[i] <= 32'(i * 5);
            end
        end else begin
            if (rr_mem_write && rr_mem_addr < 32) mem_rr[rr_mem_addr[4:0]] <= rr_mem_wdata;
            if (fp_mem_write && fp_mem_addr < 32) mem_fp[fp_mem_addr[4:0]] <= fp_mem_wdata;
        end
    end
    assign rr_mem_rdata = (rr_mem_addr < 32) ? mem_rr[rr_mem_addr[4:0]] : '0;
    assign fp_mem_rdata = (fp_mem_addr < 32) ? mem_fp[fp_mem_addr[4:0]] : '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_both(input logic port, input logic err, input logic [31:0] rdata);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rdata;
        q_rr.push_back(e);
        q_fp.push_back(e);
    endtask

    task automatic monitor(input string tag, input bit use_rr,
                           input logic a0, input logic e0, input logic [31:0] r0,
                           input logic a1, input logic e1, input logic [31:0] r1,
                           input logic mw, input logic mr);
        exp_t e;
        check({tag, "_strobe_exclusive"}, 32'(mw & mr), 32'd0);
        if (!a0) begin
            check({tag, "_p0_idle_rdata"}, r0, 32'd0);
            check({tag, "_p0_idle_err"}, 32'(e0), 32'd0);
        end
        if (!a1) begin
            check({tag, "_p1_idle_rdata"}, r1, 32'd0);
            check({tag, "_p1_idle_err"}, 32'(e1), 32'd0);
        end
        if (a0 || a1) begin
            check({tag, "_single_ack"}, 32'(a0 & a1), 32'd0);
            if (use_rr) begin
                check({tag, "_ack_expected"}, 32'(q_rr.size() != 0), 32'd1);
                if (q_rr.size() != 0) begin
                    e = q_rr.pop_front();
                    check({tag, "_ack_port"}, 32'(a1), 32'(e.port));
                    check({tag, "_ack_err"}, 32'(a1 ? e1 : e0), 32'(e.err));
                    check({tag, "_ack_rdata"}, a1 ? r1 : r0, e.rdata);
                end
            end else begin
                check({tag, "_ack_expected"}, 32'(q_fp.size() != 0), 32'd1);
                if (q_fp.size() != 0) begin
                    e = q_fp.pop_front();
                    check({tag, "_ack_port"}, 32'(a1), 32'(e.port));
                    check({tag, "_ack_err"}, 32'(a1 ? e1 : e0), 32'(e.err));
                    check({tag, "_ack_rdata"}, a1 ? r1 : r0, e.rdata);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        monitor("rr", 1'b1, rr_p0_ack, rr_p0_err, rr_p0_rdata, rr_p1_ack, rr_p1_err, rr_p1_rdata,
                rr_mem_write, rr_mem_read);
        monitor("fp", 1'b0, fp_p0_ack, fp_p0_err, fp_p0_rdata, fp_p1_ack, fp_p1_err, fp_p1_rdata,
                fp_mem_write, fp_mem_read);
        if (rr_mem_write) write_cycles++;
        if (rr_mem_read) read_cycles++;
        if (rr_p0_ack || rr_p1_ack) acks_rr++;
        if (rr_p1_ack) p1_acks_rr++;
    end

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!rr_busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 32'(rr_busy), 32'd0);
    endtask

    // Presents a one-cycle request at a negedge while IDLE; returns at the
    // negedge of the cycle after the grant edge.
    task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        @(negedge clk);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(rr_busy), 32'd0);
        check("reset_mem_write", 32'(rr_mem_write), 32'd0);
        check("reset_mem_read", 32'(rr_mem_read), 32'd0);
        check("reset_p0_ack", 32'(rr_p0_ack), 32'd0);
        check("reset_p1_ack", 32'(rr_p1_ack), 32'd0);
        check("reset_mem_addr", rr_mem_addr, 32'd0);
        reset_n = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);

        // Single read from port 0, addr 4 -> 20.
        wait_idle();
        push_both(1'b0, 1'b0, 32'd20);
        issue(1'b0, 1'b0, 32'd4, 32'd0);
        check("rd_strobe_n1", 32'(rr_mem_read), 32'd1);
        check("rd_nowrite_n1", 32'(rr_mem_write), 32'd0);
        check("rd_addr_n1", rr_mem_addr, 32'd4);
        check("rd_noack_n1", 32'(rr_p0_ack), 32'd0);
        @(negedge clk);
        check("rd_ack_n2", 32'(rr_p0_ack), 32'd1);
        check("rd_data_n2", rr_p0_rdata, 32'd20);
        check("rd_strobe_off_n2", 32'(rr_mem_read), 32'd0);

        // Write then read back from port 1.
        wait_idle();
        base = write_cycles;
        push_both(1'b1, 1'b0, 32'd0);
        issue(1'b1, 1'b1, 32'd7, 32'hDEAD);
        check("wr_strobe", 32'(rr_mem_write), 32'd1);
        check("wr_data", rr_mem_wdata, 32'hDEAD);
        @(negedge clk);
        check("wr_ack", 32'(rr_p1_ack), 32'd1);
        wait_idle();
        check("wr_one_cycle", 32'(write_cycles - base), 32'd1);
        check("wr_mem_content", mem_rr[7], 32'hDEAD);
        push_both(1'b1, 1'b0, 32'hDEAD);
        issue(1'b1, 1'b0, 32'd7, 32'd0);
        @(negedge clk);
        check("rb_data", rr_p1_rdata, 32'hDEAD);

        // Out-of-range read: error ack one cycle after grant, no strobe.
        wait_idle();
        base = write_cycles + read_cycles;
        push_both(1'b0, 1'b1, 32'd0);
        issue(1'b0, 1'b0, 32'd32, 32'd0);
        check("oor_ack_n1", 32'(rr_p0_ack), 32'd1);
        check("oor_err_n1", 32'(rr_p0_err), 32'd1);
        check("oor_rdata_n1", rr_p0_rdata, 32'd0);
        check("oor_busy_n1", 32'(rr_busy), 32'd1);
        wait_idle();
        check("oor_no_strobe", 32'(write_cycles + read_cycles - base), 32'd0);

        // Withdrawn request: p1 pulsed during p0's access, gone before IDLE.
        wait_idle();
        base = p1_acks_rr;
        push_both(1'b0, 1'b0, 32'd25);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd5;
        @(negedge clk);
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'd9; p1_wdata = 32'h1234;
        @(negedge clk);
        p1_req = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("withdraw_no_p1_ack", 32'(p1_acks_rr - base), 32'd0);
        check("withdraw_mem_untouched", mem_rr[9], 32'd45);

        // Reset in the middle of a port-1 write access.
        wait_idle();
        issue(1'b1, 1'b1, 32'd3, 32'hBEEF);
        check("rst_pre_strobe", 32'(rr_mem_write), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_strobe_drop", 32'(rr_mem_write), 32'd0);
        check("rst_busy_drop", 32'(rr_busy), 32'd0);
        check("rst_no_ack", 32'(rr_p1_ack), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_mem_rr_unchanged", mem_rr[3], 32'd15);
        check("rst_mem_fp_unchanged", mem_fp[3], 32'd15);
        repeat (3) @(negedge clk);

        // Contention with both requests held for four transactions.
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.err = 1'b0;
            e.port = 1'(i % 2);
            e.rdata = (i % 2 == 1) ? 32'd10 : 32'd5;
            q_rr.push_back(e);
            e.port = 1'b0;
            e.rdata = 32'd5;
            q_fp.push_back(e);
        end
        base = acks_rr;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd1;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (acks_rr - base >= 4) break;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check("contention_ack_count", 32'(acks_rr - base), 32'd4);

        for (int i = 0; i < 20; i++) begin
            if (q_rr.size() == 0 && q_fp.size() == 0) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("rr_queue_drained", 32'(q_rr.size()), 32'd0);
        check("fp_queue_drained", 32'(q_fp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
